// File: rtl/atm_pkg.sv
// Shared constants for the ATM keypad entry stage: key codes, modes, error codes, FSM states.
package atm_pkg;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_BACK   = 4'hB;
    localparam logic [3:0] KEY_ENTER  = 4'hE;
    localparam logic [3:0] KEY_CANCEL = 4'hF;

    localparam logic MODE_PIN = 1'b0;
    localparam logic MODE_AMT = 1'b1;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_SHORT_PIN = 2'd1;
    localparam logic [1:0] ERR_AMOUNT    = 2'd2;
    localparam logic [1:0] ERR_ABORT     = 2'd3;

    localparam logic [2:0] PIN_DIGITS = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StConvert,
        StDone,
        StErr
    } state_t;

endpackage

// File: rtl/bcd_to_bin_step.sv
// One decimal-to-binary conversion step: result = acc*10 + digit, flagging values above 16 bits.
module bcd_to_bin_step (
    input  logic [16:0] acc,
    input  logic [3:0]  digit,
    output logic [16:0] result,
    output logic        ovf
);

    logic [20:0] wide;

    always_comb begin
        wide   = {4'b0000, acc} * 21'd10 + {17'b0, digit};
        result = wide[16:0];
        ovf    = |wide[20:16];
    end

endmodule

// File: rtl/atm_keypad_entry.sv
// Keypad entry stage: collects a 4-digit BCD PIN or a decimal amount converted to binary.
// Optional inactivity timeout is enabled with `define ATM_KEYPAD_TIMEOUT_EN.
module atm_keypad_entry
    import atm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_AMT_DIGITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [2:0]  digit_cnt
);

    localparam logic [2:0] AmtLimit = 3'(MAX_AMT_DIGITS);

    state_t      state;
    logic        mode_q;
    logic [19:0] bcd;
    logic [2:0]  conv_idx;
    logic [16:0] acc;
    logic [19:0] bcd_shifted;
    logic [3:0]  conv_digit;
    logic [16:0] step_result;
    logic        step_ovf;
    logic        key_accept;
    logic [2:0]  limit;

`ifdef ATM_KEYPAD_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    logic [TimerW-1:0] timer;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    assign key_ready  = (state == StCollect);
    assign busy       = (state != StIdle);
    assign key_accept = key_valid && key_ready;
    assign limit      = (mode_q == MODE_AMT) ? AmtLimit : PIN_DIGITS;

    // Oldest digit sits in the highest occupied nibble; conversion walks conv_idx down to 0.
    assign bcd_shifted = bcd >> {conv_idx, 2'b00};
    assign conv_digit  = bcd_shifted[3:0];

    bcd_to_bin_step u_step (
        .acc    (acc),
        .digit  (conv_digit),
        .result (step_result),
        .ovf    (step_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            mode_q      <= MODE_PIN;
            bcd         <= '0;
            conv_idx    <= '0;
            acc         <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            digit_cnt   <= '0;
`ifdef ATM_KEYPAD_TIMEOUT_EN
            timer       <= '0;
`endif
        end else begin
            value_valid <= 1'b0;
            err         <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        mode_q    <= mode;
                        bcd       <= '0;
                        digit_cnt <= '0;
                        err_code  <= ERR_NONE;
                        state     <= StCollect;
`ifdef ATM_KEYPAD_TIMEOUT_EN
                        timer     <= '0;
`endif
                    end
                end
                StCollect: begin
                    if (key_accept) begin
`ifdef ATM_KEYPAD_TIMEOUT_EN
                        timer <= '0;
`endif
                        if (key_code <= 4'd9) begin
                            if (digit_cnt != limit) begin
                                bcd       <= {bcd[15:0], key_code};
                                digit_cnt <= digit_cnt + 3'd1;
                            end
                        end else begin
                            case (key_code)
                                KEY_CLEAR: begin
                                    bcd       <= '0;
                                    digit_cnt <= '0;
                                end
                                KEY_BACK: begin
                                    if (digit_cnt != 3'd0) begin
                                        bcd       <= bcd >> 4;
                                        digit_cnt <= digit_cnt - 3'd1;
                                    end
                                end
                                KEY_CANCEL: begin
                                    err_code <= ERR_ABORT;
                                    err      <= 1'b1;
                                    state    <= StErr;
                                end
                                KEY_ENTER: begin
                                    if (mode_q == MODE_PIN) begin
                                        if (digit_cnt == PIN_DIGITS) begin
                                            value       <= bcd[15:0];
                                            value_valid <= 1'b1;
                                            state       <= StDone;
                                        end else begin
                                            err_code <= ERR_SHORT_PIN;
                                            err      <= 1'b1;
                                            state    <= StErr;
                                        end
                                    end else if (digit_cnt == 3'd0) begin
                                        err_code <= ERR_AMOUNT;
                                        err      <= 1'b1;
                                        state    <= StErr;
                                    end else begin
                                        acc      <= '0;
                                        conv_idx <= digit_cnt - 3'd1;
                                        state    <= StConvert;
                                    end
                                end
                                default: ;
                            endcase
                        end
`ifdef ATM_KEYPAD_TIMEOUT_EN
                    end else if (timer == TimerLast) begin
                        err_code <= ERR_ABORT;
                        err      <= 1'b1;
                        state    <= StErr;
                    end else begin
                        timer <= timer + 1'b1;
`endif
                    end
                end
                StConvert: begin
                    acc <= step_result;
                    if (conv_idx == 3'd0) begin
                        if (step_ovf || step_result == 17'd0) begin
                            err_code <= ERR_AMOUNT;
                            err      <= 1'b1;
                            state    <= StErr;
                        end else begin
                            value       <= step_result[15:0];
                            value_valid <= 1'b1;
                            state       <= StDone;
                        end
                    end else begin
                        conv_idx <= conv_idx - 3'd1;
                    end
                end
                StDone:  state <= StIdle;
                StErr:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule
